// File: rtl/pll_lock_reset_seq.sv
// PLL lock supervisor: pulses the PLL reset, qualifies a stable lock, then
// releases the downstream domain resets one stage at a time.
module pll_lock_reset_seq #(
  parameter int ARESET_CYCLES      = 10,
  parameter int LOCK_TIMEOUT       = 100000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int NUM_STAGES         = 3,
  parameter int STAGE_GAP          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  output logic                  pll_areset,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  ready,
  output logic [7:0]            lock_loss_cnt,
  output logic [7:0]            retry_cnt
);

  localparam int REL_CYCLES = NUM_STAGES * STAGE_GAP;
  localparam int MAX_AS     = (ARESET_CYCLES > LOCK_STABLE_CYCLES) ? ARESET_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX    = (MAX_AS > REL_CYCLES) ? MAX_AS : REL_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int TMO_W      = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_ARESET    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  lk_q, lk_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [7:0]            loss_q, loss_d;
  logic [7:0]            retry_q, retry_d;
  logic                  pll_areset_q, pll_areset_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [NUM_STAGES-1:0] stage_hit;
  logic                  timeout;
  logic                  entering_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARESET;
      sync1_q      <= 1'b0;
      lk_q         <= 1'b0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      loss_q       <= '0;
      retry_q      <= '0;
      pll_areset_q <= 1'b1;
      rst_out_q    <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      lk_q         <= lk_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      loss_q       <= loss_d;
      retry_q      <= retry_d;
      pll_areset_q <= pll_areset_d;
      rst_out_q    <= rst_out_d;
      ready_q      <= ready_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (tmo_q == TMO_W'(LOCK_TIMEOUT - 1));

  // cnt_q is shared: ARESET width, lock qualification, then release spacing.
  always_comb begin
    sync1_d = pll_locked;
    lk_d    = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_inc;
    tmo_d   = tmo_q;
    loss_d  = loss_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_ARESET: begin
        tmo_d = '0;
        if (cnt_q == CNT_W'(ARESET_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        tmo_d = tmo_q + 1'b1;
        if (timeout) begin
          state_d = ST_ARESET;
          cnt_d   = '0;
          tmo_d   = '0;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end else if (!lk_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (state_q == ST_WAIT_LOCK) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (!lk_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          tmo_d   = '0;
          if (state_q == ST_RUN && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (state_q == ST_RUN) begin
          cnt_d = cnt_q;
        end else if (cnt_inc == CNT_W'(REL_CYCLES)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_ARESET;
        cnt_d   = '0;
      end
    endcase
  end

  assign entering_release = (state_q != ST_RELEASE);

  // Stage k comes out of reset once k*STAGE_GAP cycles have elapsed in RELEASE.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    assign stage_hit[gi] = entering_release ? (gi == 0)
                                            : (cnt_inc == CNT_W'(gi * STAGE_GAP));
  end

  always_comb begin
    pll_areset_d = (state_d == ST_ARESET);
    ready_d      = (state_d == ST_RUN);
    rst_out_d    = '0;
    if (state_d == ST_RUN) begin
      rst_out_d = '1;
    end else if (state_d == ST_RELEASE) begin
      rst_out_d = rst_out_q | stage_hit;
    end
  end

  assign pll_areset    = pll_areset_q;
  assign rst_out_n     = rst_out_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
  assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed table, multi-cycle corner sequences and
// randomized lock stimulus checked every cycle against a timeline model.
module tb_pll_lock_reset_seq;

  localparam int A    = 4;
  localparam int TMO  = 64;
  localparam int STAB = 8;
  localparam int N    = 3;
  localparam int G    = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pll_locked;
  logic         pll_areset;
  logic [N-1:0] rst_out_n;
  logic         ready;
  logic [7:0]   lock_loss_cnt;
  logic [7:0]   retry_cnt;

  int n_checks;
  int n_fail;

  pll_lock_reset_seq #(
    .ARESET_CYCLES      (A),
    .LOCK_TIMEOUT       (TMO),
    .LOCK_STABLE_CYCLES (STAB),
    .NUM_STAGES         (N),
    .STAGE_GAP          (G)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .pll_areset    (pll_areset),
    .rst_out_n     (rst_out_n),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt),
    .retry_cnt     (retry_cnt)
  );

  always #5 clk = ~clk;

  // Timeline model: each phase remembers the edge at which it began, and the
  // outputs follow from elapsed time since that edge.
  typedef enum {M_PULSE, M_SEEK, M_QUAL, M_SEQ, M_UP} mphase_t;
  mphase_t m_ph;
  int      m_t, m_pulse_t0, m_seek_t0, m_seq_t0, m_run, m_loss, m_retry;
  logic    m_pipe[$];

  task automatic model_reset();
    m_ph = M_PULSE; m_t = 0; m_pulse_t0 = 0; m_seek_t0 = 0; m_seq_t0 = 0;
    m_run = 0; m_loss = 0; m_retry = 0;
    m_pipe = '{1'b0, 1'b0};
  endtask

  task automatic model_step();
    logic lk;
    lk = m_pipe.pop_front();
    m_pipe.push_back(pll_locked);
    m_t++;
    case (m_ph)
      M_PULSE: if (m_t - m_pulse_t0 == A) begin m_ph = M_SEEK; m_seek_t0 = m_t; end
      M_SEEK, M_QUAL: begin
        if (m_t - m_seek_t0 == TMO) begin
          m_ph = M_PULSE; m_pulse_t0 = m_t;
          if (m_retry < 255) m_retry++;
        end else if (!lk) begin
          m_ph = M_SEEK;
        end else if (m_ph == M_SEEK) begin
          m_ph = M_QUAL; m_run = 0;
        end else begin
          m_run++;
          if (m_run == STAB) begin m_ph = M_SEQ; m_seq_t0 = m_t; end
        end
      end
      M_SEQ, M_UP: begin
        if (!lk) begin
          if (m_ph == M_UP && m_loss < 255) m_loss++;
          m_ph = M_SEEK; m_seek_t0 = m_t;
        end else if (m_ph == M_SEQ && m_t - m_seq_t0 == N * G) begin
          m_ph = M_UP;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_out();
    logic [N-1:0] m;
    int           k;
    m = '0;
    if (m_ph == M_SEQ) begin
      k = (m_t - m_seq_t0) / G + 1;
      if (k > N) k = N;
      m = N'((1 << k) - 1);
    end else if (m_ph == M_UP) begin
      m = '1;
    end
    return 32'({m_ph == M_PULSE, m, m_ph == M_UP, 8'(m_loss), 8'(m_retry)});
  endfunction

  function automatic logic [31:0] dut_out();
    return 32'({pll_areset, rst_out_n, ready, lock_loss_cnt, retry_cnt});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  endtask

  task automatic check_loop();
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("cycle_model", dut_out(), model_out());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lock);
    rst_n      = 1'b0;
    pll_locked = lock;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int max_cyc, input string name);
    int n;
    n = 0;
    while (!ready && n < max_cyc) begin
      step();
      n++;
    end
    check(name, 32'(ready), 32'd1);
  endtask

  typedef struct {
    int           cyc;
    logic         areset;
    logic [N-1:0] rst;
    logic         rdy;
    logic [7:0]   loss;
    logic [7:0]   retry;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic prev;
    int   cur, rises, nz;

    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    pll_locked = 1'b1;

    // Power-up with lock present; cyc counts clk edges after rst_n release.
    tbl[0]  = '{1,  1'b1, 3'b000, 1'b0, 8'd0, 8'd0};
    tbl[1]  = '{3,  1'b1, 3'b000, 1'b0, 8'd0, 8'd0};
    tbl[2]  = '{4,  1'b0, 3'b000, 1'b0, 8'd0, 8'd0};
    tbl[3]  = '{12, 1'b0, 3'b000, 1'b0, 8'd0, 8'd0};
    tbl[4]  = '{13, 1'b0, 3'b001, 1'b0, 8'd0, 8'd0};
    tbl[5]  = '{14, 1'b0, 3'b001, 1'b0, 8'd0, 8'd0};
    tbl[6]  = '{15, 1'b0, 3'b011, 1'b0, 8'd0, 8'd0};
    tbl[7]  = '{16, 1'b0, 3'b011, 1'b0, 8'd0, 8'd0};
    tbl[8]  = '{17, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0};
    tbl[9]  = '{18, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0};
    tbl[10] = '{19, 1'b0, 3'b111, 1'b1, 8'd0, 8'd0};
    tbl[11] = '{25, 1'b0, 3'b111, 1'b1, 8'd0, 8'd0};

    fork
      model_loop();
      check_loop();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_out(), 32'({1'b1, 3'b000, 1'b0, 8'd0, 8'd0}));
    rst_n = 1'b1;

    cur = 0;
    for (int i = 0; i < 12; i++) begin
      while (cur < tbl[i].cyc) begin
        step();
        cur++;
      end
      check($sformatf("powerup_edge%0d", tbl[i].cyc), dut_out(),
            32'({tbl[i].areset, tbl[i].rst, tbl[i].rdy, tbl[i].loss, tbl[i].retry}));
      $display("vec %0d: edge %0d areset=%b rst_out_n=%b ready=%b", i, tbl[i].cyc,
               pll_areset, rst_out_n, ready);
    end

    // Lock loss in RUN: three-edge latency, then full re-sequence.
    pll_locked = 1'b0;
    repeat (2) step();
    check("loss_latency_hold", 32'({rst_out_n, ready}), 32'({3'b111, 1'b1}));
    step();
    check("loss_outputs", 32'({rst_out_n, ready, lock_loss_cnt}), 32'({3'b000, 1'b0, 8'd1}));
    pll_locked = 1'b1;
    wait_ready(60, "resequence_ready");
    check("resequence_state", 32'({rst_out_n, lock_loss_cnt}), 32'({3'b111, 8'd1}));
    $display("lock loss: lock_loss_cnt=%0d after re-sequence", lock_loss_cnt);

    // No lock at all: PLL reset re-pulses every TMO+A edges.
    do_reset(1'b0);
    prev  = 1'b1;
    rises = 0;
    nz    = 0;
    for (int e = 1; e <= 210; e++) begin
      step();
      if (rst_out_n != '0) nz++;
      if (pll_areset && !prev) begin
        rises++;
        check("retry_period", 32'(e), 32'(rises * (A + TMO)));
        check("retry_cnt", 32'(retry_cnt), 32'(rises));
        $display("retry %0d at edge %0d retry_cnt=%0d", rises, e, retry_cnt);
      end
      prev = pll_areset;
    end
    check("retry_rises", 32'(rises), 32'd3);
    check("stages_held", 32'(nz), 32'd0);

    // One-cycle lock glitch during qualification restarts the stable count.
    do_reset(1'b1);
    repeat (6) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    repeat (10) step();
    check("glitch_hold", 32'(rst_out_n), 32'd0);
    step();
    check("glitch_release", 32'(rst_out_n), 32'b001);
    $display("glitch: rst_out_n=%b at edge 18", rst_out_n);

    // 256 lock losses saturate the counter.
    do_reset(1'b1);
    for (int i = 0; i < 256; i++) begin
      wait_ready(80, "sat_ready");
      pll_locked = 1'b0;
      repeat (3) step();
      pll_locked = 1'b1;
      if (i == 254) check("loss_255", 32'(lock_loss_cnt), 32'd255);
    end
    check("loss_saturated", 32'(lock_loss_cnt), 32'd255);
    $display("saturation: lock_loss_cnt=%0d after 256 losses", lock_loss_cnt);

    // Asynchronous reset mid-RELEASE clears everything without a clock edge.
    cur = 0;
    while (rst_out_n != 3'b001 && cur < 60) begin
      step();
      cur++;
    end
    check("reach_release", 32'(rst_out_n), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", dut_out(), 32'({1'b1, 3'b000, 1'b0, 8'd0, 8'd0}));
    $display("async reset: areset=%b rst_out_n=%b loss=%0d", pll_areset, rst_out_n, lock_loss_cnt);

    // Randomized lock behaviour with occasional asynchronous resets.
    do_reset(1'b1);
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      len        = $urandom_range(1, 40);
      pll_locked = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      repeat (len) step();
    end
    $display("random phase done: loss=%0d retry=%0d", lock_loss_cnt, retry_cnt);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
